// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : acc_pkg
// Desc     : Shared op-code and state types for the accumulator register bank.
// Revision : 1.0
// ============================================================================
package acc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ROL = 3'b111
    } acc_op_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } acc_state_t;

    function automatic logic is_shift_op(input acc_op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// ============================================================================
// Module   : acc_alu
// Desc     : Single-cycle accumulator ALU (add, subtract, bitwise logic).
// Revision : 1.0
// ============================================================================
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_operand,
    input  acc_op_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    // Subtraction borrow falls out as the extra top bit of the widened difference.
    always_comb begin
        w_sum    = '0;
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_operand};
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sum    = {1'b0, i_a} - {1'b0, i_operand};
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_AND:  o_result = i_a & i_operand;
            OP_OR:   o_result = i_a | i_operand;
            OP_XOR:  o_result = i_a ^ i_operand;
            default: o_result = i_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_regbank.sv
`default_nettype none
// ============================================================================
// Module   : acc_regbank
// Desc     : Register bank with bus load/read-out and an accumulator ALU on A.
// Revision : 1.0
// ============================================================================
module acc_regbank
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 2,
    parameter int SELW  = (NREG > 2) ? $clog2(NREG) : 1,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic                  CLK,
    input  logic                  CLRn,
    input  logic [WIDTH-1:0]      Din,
    input  logic [SELW-1:0]       WSEL,
    input  logic                  Wn,
    input  logic [SELW-1:0]       RSEL,
    input  logic                  En,
    output logic [WIDTH-1:0]      Dout,
    output logic                  DOE,
    input  logic [2:0]            OP,
    input  logic                  OPn,
    input  logic [SHW-1:0]        SHAMT,
    output logic [NREG*WIDTH-1:0] Q,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CF,
    output logic                  ZF
);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    acc_op_t          w_op;
    acc_op_t          r_shop;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [SHW-1:0]   r_cnt;
    logic             r_cf;
    logic             r_zf;
    logic             r_done;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_opnd;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_shift_res;
    logic             w_alu_cy;
    logic             w_shift_cy;
    logic             w_op_go;
    logic             w_is_shift;
    logic             w_last;
    logic             w_load_a;

    assign w_a        = r_regs[0];
    assign w_op       = acc_op_t'(OP);
    assign w_is_shift = is_shift_op(w_op);
    assign w_op_go    = !OPn && (r_state == IDLE);
    assign w_last     = (r_cnt == SHW'(1));
    assign w_load_a   = !Wn && (WSEL == '0);

    // Out-of-range selects read as zero when NREG is not a power of two.
    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(RSEL) == i) begin
                w_opnd = r_regs[i];
            end
        end
    end

    acc_alu #(
        .WIDTH     (WIDTH)
    ) u_alu (
        .i_a       (w_a),
        .i_operand (w_opnd),
        .i_op      (w_op),
        .o_result  (w_alu_res),
        .o_carry   (w_alu_cy)
    );

    always_comb begin
        w_shift_res = {w_a[WIDTH-2:0], 1'b0};
        w_shift_cy  = w_a[WIDTH-1];
        case (r_shop)
            OP_SHR: begin
                w_shift_res = {1'b0, w_a[WIDTH-1:1]};
                w_shift_cy  = w_a[0];
            end
            OP_ROL:  w_shift_res = {w_a[WIDTH-2:0], w_a[WIDTH-1]};
            default: w_shift_res = {w_a[WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_op_go && w_is_shift && (SHAMT != '0)) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A accepted op owns A for that edge, so a same-edge load to A is dropped.
    always_comb begin
        w_a_nxt = w_a;
        if (r_state == SHIFT) begin
            w_a_nxt = w_shift_res;
        end else if (w_op_go) begin
            if (!w_is_shift) begin
                w_a_nxt = w_alu_res;
            end
        end else if (w_load_a) begin
            w_a_nxt = Din;
        end
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs[0] <= w_a_nxt;
            for (int i = 1; i < NREG; i++) begin
                if (!Wn && (int'(WSEL) == i)) begin
                    r_regs[i] <= Din;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            r_state <= IDLE;
            r_shop  <= OP_SHL;
            r_cnt   <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (r_state == SHIFT) begin
                r_cf  <= w_shift_cy;
                r_cnt <= r_cnt - SHW'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    r_zf   <= (w_shift_res == '0);
                end
            end else if (w_op_go) begin
                r_done <= !(w_is_shift && (SHAMT != '0));
                if (w_is_shift) begin
                    r_shop <= w_op;
                    r_cnt  <= SHAMT;
                    if (SHAMT == '0) begin
                        r_zf <= (w_a == '0);
                    end
                end else begin
                    r_zf <= (w_alu_res == '0);
                    if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                        r_cf <= w_alu_cy;
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_q
        assign Q[gi*WIDTH +: WIDTH] = r_regs[gi];
    end

    assign Dout = En ? '0 : w_opnd;
    assign DOE  = ~En;
    assign BUSY = (r_state == SHIFT);
    assign DONE = r_done;
    assign CF   = r_cf;
    assign ZF   = r_zf;

endmodule
`default_nettype wire

// File: tb/tb_acc_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_regbank
// Desc     : Self-checking bench for acc_regbank (WIDTH=8, NREG=4).
// Revision : 1.0
// ============================================================================
module tb_acc_regbank;

    logic        CLK = 1'b0;
    logic        CLRn;
    logic [7:0]  Din;
    logic [1:0]  WSEL;
    logic        Wn;
    logic [1:0]  RSEL;
    logic        En;
    logic [7:0]  Dout;
    logic        DOE;
    logic [2:0]  OP;
    logic        OPn;
    logic [3:0]  SHAMT;
    logic [31:0] Q;
    logic        BUSY;
    logic        DONE;
    logic        CF;
    logic        ZF;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_r [4];
    logic        m_cf;
    logic        m_zf;

    acc_regbank #(
        .WIDTH (8),
        .NREG  (4)
    ) dut (
        .CLK   (CLK),
        .CLRn  (CLRn),
        .Din   (Din),
        .WSEL  (WSEL),
        .Wn    (Wn),
        .RSEL  (RSEL),
        .En    (En),
        .Dout  (Dout),
        .DOE   (DOE),
        .OP    (OP),
        .OPn   (OPn),
        .SHAMT (SHAMT),
        .Q     (Q),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .CF    (CF),
        .ZF    (ZF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Final result of a whole op computed directly from the op rules.
    task automatic model_op(input int op, input logic [7:0] a, input logic [7:0] b, input int k,
                            input logic cf_in, output logic [7:0] ra, output logic rc);
        int s;
        ra = a;
        rc = cf_in;
        case (op)
            0: begin s = int'(a) + int'(b); ra = 8'(s); rc = (s > 255); end
            1: begin ra = a - b; rc = (a < b); end
            2: ra = a & b;
            3: ra = a | b;
            4: ra = a ^ b;
            5: if (k > 0) begin ra = (k >= 8) ? 8'h00 : 8'(a << k); rc = (k <= 8) ? a[8-k] : 1'b0; end
            6: if (k > 0) begin ra = (k >= 8) ? 8'h00 : 8'(a >> k); rc = (k <= 8) ? a[k-1] : 1'b0; end
            default: if (k > 0) begin
                s  = k % 8;
                ra = 8'((a << s) | (a >> (8 - s)));
                rc = ra[0];
            end
        endcase
    endtask

    task automatic do_load(input int sel, input logic [7:0] d);
        WSEL = 2'(sel);
        Din  = d;
        Wn   = 1'b0;
        tick();
        Wn   = 1'b1;
        m_r[sel] = d;
        check("load", {24'h0, Q[sel*8 +: 8]}, {24'h0, d});
    endtask

    task automatic do_op(input int op, input int rsel, input int k);
        logic [7:0] ea;
        logic       ec;
        int         n;
        model_op(op, m_r[0], m_r[rsel], k, m_cf, ea, ec);
        OP    = 3'(op);
        RSEL  = 2'(rsel);
        SHAMT = 4'(k);
        OPn   = 1'b0;
        tick();
        OPn   = 1'b1;
        if (op >= 5 && k > 0) begin
            n = 1;
            check("busy_start", {31'h0, BUSY}, 32'h1);
            while (BUSY === 1'b1 && n < 40) begin
                tick();
                if (BUSY === 1'b1) n++;
            end
            check("busy_len", n, k);
        end else begin
            check("no_busy", {31'h0, BUSY}, 32'h0);
        end
        m_r[0] = ea;
        m_cf   = ec;
        m_zf   = (ea == 8'h00);
        check("done", {31'h0, DONE}, 32'h1);
        check("op_a", {24'h0, Q[7:0]}, {24'h0, ea});
        check("op_cf", {31'h0, CF}, {31'h0, m_cf});
        check("op_zf", {31'h0, ZF}, {31'h0, m_zf});
        tick();
        check("done_clr", {31'h0, DONE}, 32'h0);
    endtask

    initial begin
        int n;
        int rs;
        CLRn = 1'b1; Din = '0; WSEL = '0; Wn = 1'b1; RSEL = '0; En = 1'b1;
        OP = '0; OPn = 1'b1; SHAMT = '0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_cf = 1'b0;
        m_zf = 1'b1;
        #1 CLRn = 1'b0;
        #10;
        check("rst_q", Q, 32'h0);
        check("rst_cf", {31'h0, CF}, 32'h0);
        check("rst_zf", {31'h0, ZF}, 32'h1);
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_done", {31'h0, DONE}, 32'h0);
        check("rst_dout", {24'h0, Dout}, 32'h0);
        check("rst_doe", {31'h0, DOE}, 32'h0);
        @(negedge CLK);
        CLRn = 1'b1;
        tick();

        do_load(0, 8'h07);
        do_load(1, 8'h06);
        check("q_ab", {16'h0, Q[15:0]}, 32'h0607);
        RSEL = 2'd1; En = 1'b0; #1;
        check("dout_b", {24'h0, Dout}, 32'h06);
        check("doe_on", {31'h0, DOE}, 32'h1);
        En = 1'b1; #1;
        check("dout_off", {24'h0, Dout}, 32'h0);

        do_load(0, 8'hFF); do_load(1, 8'h01);
        do_op(0, 1, 0);
        do_load(0, 8'h05); do_load(1, 8'h06);
        do_op(1, 1, 0);

        // SHL by 3 on 81 with every intermediate step observed.
        do_load(0, 8'h81);
        OP = 3'd5; SHAMT = 4'd3; OPn = 1'b0;
        tick();
        OPn = 1'b1;
        check("shl_t0_busy", {31'h0, BUSY}, 32'h1);
        check("shl_t0_a", {24'h0, Q[7:0]}, 32'h81);
        tick();
        check("shl_t1_a", {24'h0, Q[7:0]}, 32'h02);
        check("shl_t1_cf", {31'h0, CF}, 32'h1);
        check("shl_t1_busy", {31'h0, BUSY}, 32'h1);
        tick();
        check("shl_t2_a", {24'h0, Q[7:0]}, 32'h04);
        check("shl_t2_busy", {31'h0, BUSY}, 32'h1);
        tick();
        check("shl_t3_a", {24'h0, Q[7:0]}, 32'h08);
        check("shl_t3_busy", {31'h0, BUSY}, 32'h0);
        check("shl_t3_done", {31'h0, DONE}, 32'h1);
        check("shl_t3_cf", {31'h0, CF}, 32'h0);
        check("shl_t3_zf", {31'h0, ZF}, 32'h0);
        tick();
        check("shl_done_clr", {31'h0, DONE}, 32'h0);
        m_r[0] = 8'h08; m_cf = 1'b0; m_zf = 1'b0;

        // ROL by 9 with loads attempted while busy.
        do_load(0, 8'h81);
        OP = 3'd7; SHAMT = 4'd9; OPn = 1'b0;
        tick();
        OPn = 1'b1;
        WSEL = 2'd0; Din = 8'hAA; Wn = 1'b0;
        tick();
        WSEL = 2'd1; Din = 8'h55;
        tick();
        Wn = 1'b1;
        check("rol_b_load", {24'h0, Q[15:8]}, 32'h55);
        check("rol_mid_a", {24'h0, Q[7:0]}, 32'h06);
        m_r[1] = 8'h55;
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin tick(); n++; end
        check("rol_len", n, 7);
        check("rol_done", {31'h0, DONE}, 32'h1);
        check("rol_a", {24'h0, Q[7:0]}, 32'h03);
        check("rol_cf", {31'h0, CF}, 32'h1);
        m_r[0] = 8'h03; m_cf = 1'b1; m_zf = 1'b0;
        tick();

        do_op(5, 0, 0);
        do_op(6, 0, 12);

        // Asynchronous reset in the middle of a shift.
        do_load(0, 8'h0F);
        OP = 3'd5; SHAMT = 4'd5; OPn = 1'b0;
        tick();
        OPn = 1'b1;
        tick(); tick();
        #2 CLRn = 1'b0;
        #1;
        check("abort_q", Q, 32'h0);
        check("abort_busy", {31'h0, BUSY}, 32'h0);
        check("abort_zf", {31'h0, ZF}, 32'h1);
        check("abort_cf", {31'h0, CF}, 32'h0);
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_cf = 1'b0; m_zf = 1'b1;
        @(negedge CLK);
        CLRn = 1'b1;
        tick();

        // Same-edge op and load.
        do_load(0, 8'h03); do_load(1, 8'h04);
        OP = 3'd0; RSEL = 2'd1; OPn = 1'b0;
        WSEL = 2'd0; Din = 8'h77; Wn = 1'b0;
        tick();
        OPn = 1'b1; Wn = 1'b1;
        check("same_a_wins", {24'h0, Q[7:0]}, 32'h07);
        check("same_a_done", {31'h0, DONE}, 32'h1);
        OPn = 1'b0; WSEL = 2'd1; Din = 8'h20; Wn = 1'b0;
        tick();
        OPn = 1'b1; Wn = 1'b1;
        check("same_b_oldop", {24'h0, Q[7:0]}, 32'h0B);
        check("same_b_load", {24'h0, Q[15:8]}, 32'h20);
        m_r[0] = 8'h0B; m_r[1] = 8'h20; m_cf = 1'b0; m_zf = 1'b0;
        tick();

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(int'($urandom_range(0, 3)), 8'($urandom));
            else
                do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 15)));
            rs = int'($urandom_range(0, 3));
            RSEL = 2'(rs); En = 1'b0; #1;
            check("rnd_dout", {24'h0, Dout}, {24'h0, m_r[rs]});
            En = 1'b1;
        end
        for (int i = 0; i < 4; i++) check("final_reg", {24'h0, Q[i*8 +: 8]}, {24'h0, m_r[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_regbank.md
# acc_regbank

Parametrised successor to the 8-bit CPU's two-register accumulator: a bank of `NREG` registers of `WIDTH` bits loaded from the data bus, with selectable bus read-out. It adds an accumulator ALU on register 0 (A), supporting single-cycle logic and arithmetic and multi-cycle serial shifts/rotates with carry and zero flags. It sits between the data bus and the controller, which sequences it with active-low strobes.

## Interface
Parameters:
- `WIDTH`, default 8: register and bus width.
- `NREG`, default 2: number of registers. Minimum 2. Register 0 is A, register 1 is B.
- `SELW`, derived, = max(1, $clog2(NREG)): register-select width.
- `SHW`, derived, = $clog2(WIDTH)+1: shift-amount width.

Ports:
- `CLK` in 1: clock; rising edge.
- `CLRn` in 1: reset, asynchronous, active-low.
- `Din` in WIDTH: bus input data.
- `WSEL` in SELW: write-select register.
- `Wn` in 1: active-low load of `Din` into R[WSEL].
- `RSEL` in SELW: read/operand-select register.
- `En` in 1: active-low bus output enable.
- `Dout` out WIDTH: R[RSEL] when `En`=0, else 0.
- `DOE` out 1: `~En`; the bus driver enable.
- `OP` in 3: ALU op code.
- `OPn` in 1: active-low op start strobe.
- `SHAMT` in SHW: shift count.
- `Q` out NREG*WIDTH: all registers flattened; R[i] is at bits [i*WIDTH +: WIDTH].
- `BUSY` out 1: shift in progress.
- `DONE` out 1: one-cycle pulse on op completion.
- `CF` out 1: carry flag.
- `ZF` out 1: zero flag.

## Operation
- Op codes:
  - 000 ADD: A <= A+R[RSEL]; CF = carry out.
  - 001 SUB: A <= A−R[RSEL]; CF = borrow (1 when A < operand).
  - 010 AND, 011 OR, 100 XOR: bitwise with R[RSEL]; CF unchanged.
  - 101 SHL: logical, 0 shifted in.
  - 110 SHR: logical, 0 shifted in.
  - 111 ROL: rotate left.
- Arithmetic is WIDTH bits modulo 2^WIDTH. The operand is the pre-edge value of R[RSEL]; RSEL=0 uses A itself.
- ZF is set to (A==0) on each op completion. Loads do not touch the flags.
- Shift state machine:
  - IDLE → SHIFT at the edge that samples a shift op with SHAMT≥1. The count is latched at that edge.
  - Each edge in SHIFT moves one bit. CF = the bit shifted out (for ROL, the bit rotated).
  - After the latched count of shift edges the machine returns to IDLE.
  - SHAMT > WIDTH is legal: SHL/SHR then yield 0, and ROL wraps.
  - SHAMT=0: A and CF unchanged, ZF updated, DONE pulses, no BUSY.
- While `BUSY`=1:
  - `OPn` is ignored.
  - `Wn` with WSEL=0 is ignored; loads to other registers proceed.
  - Reads of A show intermediate shift values.
- Same edge `OPn`=0 and `Wn`=0 with WSEL=0: the op wins and the load is dropped. With WSEL≠0 both happen, and the op uses the old R[RSEL].
- Reset values:
  - All registers 0.
  - CF=0, ZF=1.
  - BUSY=0, DONE=0, state IDLE.
  - `Dout` follows `En`; 0 when disabled.
- `CLRn` asserted mid-shift aborts the shift immediately.

## Timing
- Load: R[WSEL] = `Din` after the rising edge where `Wn`=0.
- Read: `Dout`/`DOE` are combinational from `En`, `RSEL` and the registers (zero latency).
- ALU ops 000–100: result in A and flags after the sampling edge. DONE is high for the following cycle. BUSY stays 0.
- Shift, SHAMT=k≥1:
  - BUSY is high for k cycles after the sampling edge.
  - A is final after edge k+1 counted from the sampling edge.
  - DONE is high in the cycle after BUSY falls.
  - Total latency k+1 edges.
- `OPn` is level-sampled per edge. The controller holds it low exactly one cycle per op; holding it longer in IDLE restarts the op.

## Structure
- Shared package `acc_pkg`: the op-code enum `acc_op_t` (ADD…ROL) and the state enum `acc_state_t` (IDLE, SHIFT).
- One sub-module: `acc_alu`, combinational, taking (A, operand, op) and returning (result, carry), for the single-cycle ops.
- Shift datapath, counter, flags and register array live in `acc_regbank`.

## Test plan
- Reset, then load 07 to A and 06 to B (consecutive `Wn` pulses) → Q shows A=07, B=06. `En`=0 with RSEL=1 → Dout=06, DOE=1.
- ADD, RSEL=1, A=FF, B=01 → A=00, CF=1, ZF=1, DONE pulses one cycle later.
- SUB, A=05, B=06 → A=FF, CF=1, ZF=0.
- SHL, SHAMT=3, A=81 →
  - BUSY high 3 cycles; intermediate A values 02, 04, 08.
  - Final A=08, CF=0, DONE after BUSY falls.
- ROL, SHAMT=9 on A=81 → A=03, CF=1. During BUSY, a load to A is ignored and a load to B=55 takes effect.
- `CLRn` low mid-shift → all registers 0, BUSY=0, ZF=1 immediately. Same-edge op ADD plus load to A → load dropped.
